// File: rtl/pal_cfg_pkg.sv
// Shared types and constants for the PAL config-chain loader.
// Optional CRC check is built in when PAL_CFG_CRC_EN is defined.
package pal_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        CHECK,
        DONE,
        ERROR
    } state_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    // Number of host bytes needed to carry len chain bits.
    function automatic int nbytes(input int len);
        return (len + 7) / 8;
    endfunction

endpackage

// File: rtl/pal_cfg_loader_if.sv
// Host/chain signal bundle for pal_cfg_loader.
// master: host side (start + byte stream in, status/chain out).
// slave:  the loader itself.
interface pal_cfg_loader_if;
    logic       start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       cfg_bit;
    logic       cfg_shift;
    logic       cfg_clr;
    logic       cfg_en;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output start, in_data, in_valid,
        input  in_ready, cfg_bit, cfg_shift, cfg_clr, cfg_en, busy, done, err
    );

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, cfg_bit, cfg_shift, cfg_clr, cfg_en, busy, done, err
    );
endinterface

// File: rtl/pal_crc8_serial.sv
// Bit-serial CRC-8 (poly 0x07, MSB-first, no reflection, no xor-out).
// Only instantiated when PAL_CFG_CRC_EN is defined.
module pal_crc8_serial
    import pal_cfg_pkg::*;
(
    input  logic       clk,
    input  logic       res,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic       i_bit,
    output logic [7:0] o_crc
);
    logic [7:0] r_crc;
    logic       w_fb;

    assign w_fb  = r_crc[7] ^ i_bit;
    assign o_crc = r_crc;

    // One LFSR step per payload bit shifted into the chain.
    always_ff @(posedge clk) begin
        if (res || i_clr) begin
            r_crc <= CRC8_INIT;
        end else if (i_en) begin
            r_crc <= {r_crc[6:0], 1'b0} ^ (w_fb ? CRC8_POLY : 8'h00);
        end
    end
endmodule

// File: rtl/pal_cfg_loader.sv
// Loads the PAL fabric's LEN-bit config shift chain from a host byte stream.
// Clears the chain, shifts bytes MSB-first with one-cycle strobes, then
// enables the fabric. Define PAL_CFG_CRC_EN to require a trailing CRC-8 byte.
//
//  state | meaning
//  IDLE  | waiting for start
//  CLEAR | one-cycle chain clear
//  LOAD  | accepting bytes and shifting payload bits
//  CHECK | compare received CRC with computed CRC (CRC build only)
//  DONE  | chain applied to fabric
//  ERROR | CRC mismatch, chain not applied
module pal_cfg_loader
    import pal_cfg_pkg::*;
#(
    parameter int LEN = 8
) (
    input logic             clk,
    input logic             res,
    pal_cfg_loader_if.slave bus
);
    localparam int NB = nbytes(LEN);
    localparam int CW = $clog2(LEN + 1);
    localparam int BW = $clog2(NB + 1);

    state_t        r_state;
    state_t        w_next;
    logic [7:0]    r_byte;
    logic          r_full;
    logic [2:0]    r_idx;
    logic [CW-1:0] r_cnt;
    logic [BW-1:0] r_bcnt;
    logic          w_shift;
    logic          w_last_shift;
    logic          w_more;
    logic          w_ready;
    logic          w_acc;
    logic          w_bit;
    logic          w_cnt_full;
    logic          w_payload_acc;

    assign w_shift       = (r_state == LOAD) && r_full;
    assign w_last_shift  = w_shift && ((r_idx == 3'd7) || (r_cnt == CW'(LEN - 1)));
    assign w_cnt_full    = (r_cnt == CW'(LEN));
    assign w_bit         = w_shift ? r_byte[~r_idx] : 1'b0;
    assign w_payload_acc = w_acc && (r_bcnt != BW'(NB));

`ifdef PAL_CFG_CRC_EN
    logic [7:0] r_crc_rx;
    logic       r_crc_got;
    logic [7:0] w_crc;

    // Once all payload bytes are in, one more byte (the CRC) is accepted.
    assign w_more = (r_bcnt != BW'(NB)) || !r_crc_got;

    pal_crc8_serial u_crc (
        .clk   (clk),
        .res   (res),
        .i_clr (r_state == CLEAR),
        .i_en  (w_shift),
        .i_bit (w_bit),
        .o_crc (w_crc)
    );

    // Capture the trailing CRC byte; it never enters the chain.
    always_ff @(posedge clk) begin
        if (res || (r_state == CLEAR)) begin
            r_crc_rx  <= 8'h00;
            r_crc_got <= 1'b0;
        end else if (w_acc && (r_bcnt == BW'(NB))) begin
            r_crc_rx  <= bus.in_data;
            r_crc_got <= 1'b1;
        end
    end
`else
    assign w_more = (r_bcnt != BW'(NB));
`endif

    // Ready on the last shift of the current byte too, so a steady stream has no bubbles.
    assign w_ready = (r_state == LOAD) && w_more && (!r_full || w_last_shift);
    assign w_acc   = w_ready && bus.in_valid;

    // Byte register, in-byte bit index, total shift count and byte count.
    always_ff @(posedge clk) begin
        if (res || (r_state == CLEAR)) begin
            r_byte <= 8'h00;
            r_full <= 1'b0;
            r_idx  <= 3'd0;
            r_cnt  <= '0;
            r_bcnt <= '0;
        end else begin
            if (w_shift) begin
                r_cnt <= r_cnt + 1'b1;
                r_idx <= r_idx + 1'b1;
            end
            if (w_payload_acc) begin
                r_byte <= bus.in_data;
                r_full <= 1'b1;
                r_idx  <= 3'd0;
                r_bcnt <= r_bcnt + 1'b1;
            end else if (w_last_shift) begin
                r_full <= 1'b0;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (res) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; start is only honoured from IDLE/DONE/ERROR.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (bus.start) w_next = CLEAR;
            CLEAR: w_next = LOAD;
`ifdef PAL_CFG_CRC_EN
            LOAD:  if (w_cnt_full && r_crc_got) w_next = CHECK;
            CHECK: w_next = (w_crc == r_crc_rx) ? DONE : ERROR;
`else
            LOAD:  if (w_cnt_full) w_next = DONE;
            CHECK: w_next = IDLE;
`endif
            DONE:  if (bus.start) w_next = CLEAR;
            ERROR: if (bus.start) w_next = CLEAR;
            default: w_next = IDLE;
        endcase
    end

    assign bus.in_ready  = w_ready;
    assign bus.cfg_shift = w_shift;
    assign bus.cfg_bit   = w_bit;
    assign bus.cfg_clr   = (r_state == CLEAR);
    assign bus.cfg_en    = (r_state == DONE);
    assign bus.done      = (r_state == DONE);
    assign bus.busy      = (r_state == CLEAR) || (r_state == LOAD) || (r_state == CHECK);
`ifdef PAL_CFG_CRC_EN
    assign bus.err       = (r_state == ERROR);
`else
    assign bus.err       = 1'b0;
`endif
endmodule

// File: tb/tb_pal_cfg_loader.sv
// Directed bench for pal_cfg_loader: one LEN=16 and one LEN=12 instance,
// each with a model chain driven by cfg_clr/cfg_shift/cfg_bit.
// With PAL_CFG_CRC_EN defined, every load carries a trailing CRC byte.
module tb_pal_cfg_loader;
`ifdef PAL_CFG_CRC_EN
    localparam int NCRC = 1;
`else
    localparam int NCRC = 0;
`endif
    localparam logic [7:0] CRC16_A53C = 8'hED;
    localparam logic [7:0] CRC12_FFB  = 8'h2C;

    logic       clk = 1'b0;
    logic       res;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       sel;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pal_cfg_loader_if if16 ();
    pal_cfg_loader_if if12 ();

    assign if16.start    = start & ~sel;
    assign if12.start    = start & sel;
    assign if16.in_valid = in_valid & ~sel;
    assign if12.in_valid = in_valid & sel;
    assign if16.in_data  = in_data;
    assign if12.in_data  = in_data;

    pal_cfg_loader #(.LEN(16)) u_dut16 (.clk(clk), .res(res), .bus(if16));
    pal_cfg_loader #(.LEN(12)) u_dut12 (.clk(clk), .res(res), .bus(if12));

    logic [15:0] chain16 = 16'h0;
    logic [11:0] chain12 = 12'h0;

    always @(posedge clk) begin
        if (if16.cfg_clr)        chain16 <= '0;
        else if (if16.cfg_shift) chain16 <= {chain16[14:0], if16.cfg_bit};
        if (if12.cfg_clr)        chain12 <= '0;
        else if (if12.cfg_shift) chain12 <= {chain12[10:0], if12.cfg_bit};
    end

    logic [7:0]  outs16, outs12, m_outs;
    logic [15:0] m_chain;
    assign outs16  = {if16.in_ready, if16.cfg_bit, if16.cfg_shift, if16.cfg_clr,
                      if16.cfg_en, if16.busy, if16.done, if16.err};
    assign outs12  = {if12.in_ready, if12.cfg_bit, if12.cfg_shift, if12.cfg_clr,
                      if12.cfg_en, if12.busy, if12.done, if12.err};
    assign m_outs  = sel ? outs12 : outs16;
    assign m_chain = sel ? {4'h0, chain12} : chain16;

    wire m_ready = m_outs[7];
    wire m_bit   = m_outs[6];
    wire m_shift = m_outs[5];
    wire m_clr   = m_outs[4];
    wire m_en    = m_outs[3];
    wire m_busy  = m_outs[2];
    wire m_done  = m_outs[1];
    wire m_err   = m_outs[0];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a load and stream n bytes; gap>0 holds in_valid low for the
    // first byte's 8 shifts plus gap cycles; restart_at>=0 pulses start
    // once the shift count reaches that value.
    task automatic run_load(input int n, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input int gap, input int restart_at,
                            input bit junk_with_start,
                            output int shifts, output int run_max, output int clr_cyc,
                            output int idle, output int viol, output logic [15:0] chain0,
                            output bit ok);
        logic [7:0] q[3];
        int  idx = 0, gap_left = 0, run = 0;
        bit  acc, prev_clr = 0, got0 = 0, restarted = 0;
        q[0] = b0; q[1] = b1; q[2] = b2;
        shifts = 0; run_max = 0; clr_cyc = 0; idle = 0; viol = 0; chain0 = 16'hFFFF; ok = 0;
        start = 1'b1;
        in_valid = junk_with_start;
        in_data  = 8'h00;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (prev_clr && !got0) begin chain0 = m_chain; got0 = 1; end
            prev_clr = m_clr;
            if (m_clr) clr_cyc++;
            if (m_en && !m_done) viol++;
            if (!m_shift && m_bit) viol++;
            if (m_shift) begin
                shifts++; run++;
                if (run > run_max) run_max = run;
            end else begin
                run = 0;
                if (m_busy && !m_clr && idx > 0) idle++;
            end
            if (m_done || m_err) begin ok = 1; break; end
            start = (restart_at >= 0) && (shifts == restart_at) && !restarted;
            if (start) restarted = 1;
            if (gap_left > 0) begin
                in_valid = 1'b0; gap_left--;
            end else if (idx < n) begin
                in_valid = 1'b1; in_data = q[idx];
            end else begin
                in_valid = 1'b0;
            end
            acc = in_valid && m_ready;
            tick();
            if (acc) begin
                idx++;
                if (idx == 1 && gap > 0) gap_left = 8 + gap;
            end
        end
        in_valid = 1'b0;
        start = 1'b0;
    endtask

    int sh, rm, cc, id, vi;
    logic [15:0] c0;
    bit ok;

    task automatic test_reset();
        res = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; sel = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (outs16 !== 8'h00) begin n_fail++; $display("FAIL reset_outs16 got %b want 00000000", outs16); end
        n_tests++;
        if (outs12 !== 8'h00) begin n_fail++; $display("FAIL reset_outs12 got %b want 00000000", outs12); end
        res = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        run_load(2 + NCRC, 8'hA5, 8'h3C, CRC16_A53C, 0, -1, 1'b1, sh, rm, cc, id, vi, c0, ok);
        n_tests++; if (ok !== 1'b1)         begin n_fail++; $display("FAIL b2b_timeout got %0d want 1", ok); end
        n_tests++; if (sh != 16)            begin n_fail++; $display("FAIL b2b_shifts got %0d want 16", sh); end
        n_tests++; if (rm != 16)            begin n_fail++; $display("FAIL b2b_run got %0d want 16", rm); end
        n_tests++; if (m_chain !== 16'hA53C) begin n_fail++; $display("FAIL b2b_chain got %h want a53c", m_chain); end
        n_tests++; if ({m_done, m_en, m_err} !== 3'b110) begin n_fail++; $display("FAIL b2b_status got %b want 110", {m_done, m_en, m_err}); end
        n_tests++; if (vi != 0)             begin n_fail++; $display("FAIL b2b_rules got %0d want 0", vi); end
    endtask

    task automatic test_partial_byte();
        sel = 1'b1;
        run_load(2 + NCRC, 8'hFF, 8'hB7, CRC12_FFB, 0, -1, 1'b0, sh, rm, cc, id, vi, c0, ok);
        n_tests++; if (ok !== 1'b1)           begin n_fail++; $display("FAIL len12_timeout got %0d want 1", ok); end
        n_tests++; if (sh != 12)              begin n_fail++; $display("FAIL len12_shifts got %0d want 12", sh); end
        n_tests++; if (chain12 !== 12'hFFB)   begin n_fail++; $display("FAIL len12_chain got %h want ffb", chain12); end
        n_tests++; if ({m_done, m_en} !== 2'b11) begin n_fail++; $display("FAIL len12_done got %b want 11", {m_done, m_en}); end
        sel = 1'b0;
    endtask

    task automatic test_gap();
        sel = 1'b0;
        run_load(2 + NCRC, 8'hA5, 8'h3C, CRC16_A53C, 5, -1, 1'b0, sh, rm, cc, id, vi, c0, ok);
        n_tests++; if (ok !== 1'b1)          begin n_fail++; $display("FAIL gap_timeout got %0d want 1", ok); end
        n_tests++; if (sh != 16)             begin n_fail++; $display("FAIL gap_shifts got %0d want 16", sh); end
        n_tests++; if (rm != 8)              begin n_fail++; $display("FAIL gap_run got %0d want 8", rm); end
        n_tests++; if (id < 5)               begin n_fail++; $display("FAIL gap_idle got %0d want >=5", id); end
        n_tests++; if (m_chain !== 16'hA53C) begin n_fail++; $display("FAIL gap_chain got %h want a53c", m_chain); end
    endtask

    task automatic test_reset_midload();
        sel = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        in_valid = 1'b1; in_data = 8'hA5;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        res = 1'b1;
        tick();
        n_tests++;
        if (m_outs !== 8'h00) begin n_fail++; $display("FAIL midreset_outs got %b want 00000000", m_outs); end
        res = 1'b0;
        tick();
        run_load(2 + NCRC, 8'hA5, 8'h3C, CRC16_A53C, 0, -1, 1'b0, sh, rm, cc, id, vi, c0, ok);
        n_tests++; if (ok !== 1'b1)          begin n_fail++; $display("FAIL midreset_timeout got %0d want 1", ok); end
        n_tests++; if (m_chain !== 16'hA53C) begin n_fail++; $display("FAIL midreset_chain got %h want a53c", m_chain); end
        n_tests++; if (m_done !== 1'b1)      begin n_fail++; $display("FAIL midreset_done got %b want 1", m_done); end
    endtask

    task automatic test_clear_restart();
        sel = 1'b0;
        n_tests++;
        if (chain16 !== 16'hA53C) begin n_fail++; $display("FAIL preload_chain got %h want a53c", chain16); end
        run_load(2 + NCRC, 8'h5A, 8'hC3, 8'h00, 0, 4, 1'b0, sh, rm, cc, id, vi, c0, ok);
`ifdef PAL_CFG_CRC_EN
        // 5A C3 with a zero CRC byte is a deliberate mismatch here.
        n_tests++; if (m_err !== 1'b1)       begin n_fail++; $display("FAIL restart_err got %b want 1", m_err); end
`else
        n_tests++; if (m_done !== 1'b1)      begin n_fail++; $display("FAIL restart_done got %b want 1", m_done); end
`endif
        n_tests++; if (ok !== 1'b1)          begin n_fail++; $display("FAIL restart_timeout got %0d want 1", ok); end
        n_tests++; if (cc != 1)              begin n_fail++; $display("FAIL clr_cycles got %0d want 1", cc); end
        n_tests++; if (c0 !== 16'h0000)      begin n_fail++; $display("FAIL chain_after_clr got %h want 0000", c0); end
        n_tests++; if (vi != 0)              begin n_fail++; $display("FAIL restart_rules got %0d want 0", vi); end
        n_tests++; if (sh != 16)             begin n_fail++; $display("FAIL restart_shifts got %0d want 16", sh); end
        n_tests++; if (m_chain !== 16'h5AC3) begin n_fail++; $display("FAIL restart_chain got %h want 5ac3", m_chain); end
    endtask

`ifdef PAL_CFG_CRC_EN
    task automatic test_crc();
        sel = 1'b0;
        run_load(3, 8'hA5, 8'h3C, CRC16_A53C, 0, -1, 1'b0, sh, rm, cc, id, vi, c0, ok);
        n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL crc_good_timeout got %0d want 1", ok); end
        n_tests++; if ({m_done, m_en, m_err} !== 3'b110) begin n_fail++; $display("FAIL crc_good got %b want 110", {m_done, m_en, m_err}); end
        run_load(3, 8'hA5, 8'h3C, 8'h12, 0, -1, 1'b0, sh, rm, cc, id, vi, c0, ok);
        n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL crc_bad_timeout got %0d want 1", ok); end
        n_tests++; if ({m_done, m_en, m_err} !== 3'b001) begin n_fail++; $display("FAIL crc_bad got %b want 001", {m_done, m_en, m_err}); end
        n_tests++; if (m_chain !== 16'hA53C) begin n_fail++; $display("FAIL crc_bad_chain got %h want a53c", m_chain); end
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_partial_byte();
        test_gap();
        test_reset_midload();
        test_clear_restart();
`ifdef PAL_CFG_CRC_EN
        test_crc();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
